// File: rtl/noc_vc_link_arbiter.sv
// Virtual-channel link arbiter: several VCs share one physical link through a
// single output register. Round-robin grant with per-VC credit tracking and an
// optional packet lock that keeps the link on one VC from header to tail.
//
// Handshake: a flit moves from upstream VC v when in_valid[v] && in_ready[v]
// in the same cycle; it leaves the output register when out_valid[v] &&
// out_ready[v]. in_ready never depends on out_ready of a different VC than the
// one currently held. in_vc_ready[v] pulses for one cycle after acceptance.

package noc_vc_link_arbiter_pkg;
    localparam int Noc_VC_Channel = 4;
    localparam int Noc_Data_Width = 32;
endpackage

module noc_vc_link_arbiter
    import noc_vc_link_arbiter_pkg::*;
#(
    parameter int Channel      = Noc_VC_Channel,
    parameter int Data_width   = Noc_Data_Width,
    parameter int Credit_Depth = 4,
    parameter int Packet_Lock  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Channel-1:0]            in_valid,
    output logic [Channel-1:0]            in_ready,
    input  logic [Channel*Data_width-1:0] in_flit,
    input  logic [Channel-1:0]            in_is_header,
    input  logic [Channel-1:0]            in_is_tail,
    output logic [Channel-1:0]            in_vc_ready,
    output logic [Channel-1:0]            out_valid,
    input  logic [Channel-1:0]            out_ready,
    output logic [Data_width-1:0]         out_flit,
    output logic                          out_is_header,
    output logic                          out_is_tail,
    input  logic [Channel-1:0]            out_vc_ready,
    output logic                          lock_state
);
    localparam int PtrW  = (Channel > 1) ? $clog2(Channel) : 1;
    localparam int CredW = $clog2(Credit_Depth + 1);

    typedef enum logic {LOCK_IDLE = 1'b0, LOCK_HELD = 1'b1} lock_t;

    lock_t                 lock_q, lock_d;
    logic [PtrW-1:0]       owner_q, owner_d;
    logic [PtrW-1:0]       rr_ptr;
    logic [CredW-1:0]      credit [Channel];
    logic                  hold_valid;
    logic [PtrW-1:0]       hold_vc;
    logic [Data_width-1:0] flit_arr [Channel];
    logic [Channel-1:0]    eligible;
    logic [Channel-1:0]    grant;
    logic                  any_grant;
    logic [PtrW-1:0]       grant_vc;
    logic                  can_load;

    // Register can take a new flit when empty or draining this cycle.
    assign can_load = !hold_valid || out_ready[hold_vc];

    // Split the packed flit bus into per-VC words.
    always_comb begin
        for (int v = 0; v < Channel; v++) begin
            flit_arr[v] = in_flit[v*Data_width +: Data_width];
        end
    end

    // A VC may compete when it has data, a credit, and is not shut out by a lock.
    always_comb begin
        eligible = '0;
        for (int v = 0; v < Channel; v++) begin
            eligible[v] = in_valid[v] && (credit[v] != '0) &&
                          ((Packet_Lock == 0) || (lock_q == LOCK_IDLE) ||
                           (owner_q == PtrW'(v)));
        end
    end

    // Round-robin pick: first eligible VC at or after rr_ptr, wrapping around.
    always_comb begin
        logic [PtrW:0] sum;
        logic [PtrW-1:0] idx;
        grant     = '0;
        grant_vc  = '0;
        any_grant = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < Channel; i++) begin
            sum = {1'b0, rr_ptr} + (PtrW+1)'(i);
            if (sum >= (PtrW+1)'(Channel)) sum = sum - (PtrW+1)'(Channel);
            idx = sum[PtrW-1:0];
            if (can_load && !rst && !any_grant && eligible[idx]) begin
                any_grant   = 1'b1;
                grant_vc    = idx;
                grant[idx]  = 1'b1;
            end
        end
    end

    assign in_ready = grant;

    // Output register: load on grant, empty on a drain with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid    <= 1'b0;
            hold_vc       <= '0;
            out_flit      <= '0;
            out_is_header <= 1'b0;
            out_is_tail   <= 1'b0;
        end else if (any_grant) begin
            hold_valid    <= 1'b1;
            hold_vc       <= grant_vc;
            out_flit      <= flit_arr[grant_vc];
            out_is_header <= in_is_header[grant_vc];
            out_is_tail   <= in_is_tail[grant_vc];
        end else if (can_load) begin
            hold_valid    <= 1'b0;
            hold_vc       <= '0;
            out_flit      <= '0;
            out_is_header <= 1'b0;
            out_is_tail   <= 1'b0;
        end
    end

    // Expand the held VC index into the one-hot valid tag.
    always_comb begin
        out_valid = '0;
        if (hold_valid) out_valid[hold_vc] = 1'b1;
    end

    // Round-robin pointer advances past the winner; acceptance pulse follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            in_vc_ready <= '0;
        end else begin
            in_vc_ready <= grant;
            if (any_grant) begin
                if (int'(grant_vc) == Channel - 1) rr_ptr <= '0;
                else                               rr_ptr <= grant_vc + 1'b1;
            end
        end
    end

    // Credits: spend on grant, refill on return; both at once cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int v = 0; v < Channel; v++) credit[v] <= CredW'(Credit_Depth);
        end else begin
            for (int v = 0; v < Channel; v++) begin
                if (grant[v] && !out_vc_ready[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end else if (!grant[v] && out_vc_ready[v] &&
                             credit[v] != CredW'(Credit_Depth)) begin
                    credit[v] <= credit[v] + 1'b1;
                end
            end
        end
    end

    // Flag a credit return arriving when the count is already full.
    always @(posedge clk) begin
        if (!rst) begin
            for (int v = 0; v < Channel; v++) begin
                assert (!(out_vc_ready[v] && !grant[v] &&
                          credit[v] == CredW'(Credit_Depth)))
                else $error("credit overflow on vc %0d", v);
            end
        end
    end

    // Lock state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q  <= LOCK_IDLE;
            owner_q <= '0;
        end else begin
            lock_q  <= lock_d;
            owner_q <= owner_d;
        end
    end

    // Lock next state: header without tail locks, tail of owner releases.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        if (Packet_Lock != 0 && any_grant) begin
            case (lock_q)
                LOCK_IDLE: begin
                    if (in_is_header[grant_vc] && !in_is_tail[grant_vc]) begin
                        lock_d  = LOCK_HELD;
                        owner_d = grant_vc;
                    end
                end
                LOCK_HELD: begin
                    if (in_is_tail[grant_vc]) lock_d = LOCK_IDLE;
                end
            endcase
        end
    end

    assign lock_state = (lock_q == LOCK_HELD);

endmodule
